// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// State encoding, digit width and counter sizing helper.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CONVERT = 2'd1;
    localparam logic [1:0] ST_FINISH  = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        CONVERT = ST_CONVERT,
        FINISH  = ST_FINISH
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/bcd_seq_converter_if.sv
// Request/result bundle between a client and the BCD converter.
// The client drives start/num; the converter returns status and digits.
interface bcd_seq_converter_if #(
    parameter int WIDTH  = 13,
    parameter int DIGITS = 4
);
    import bcd_pkg::*;

    logic                            start;
    logic [WIDTH-1:0]                num;
    logic                            busy;
    logic                            done;
    logic                            ovf;
    logic [DIGITS*BCD_DIGIT_W-1:0]   bcd;

    modport master (
        output start, num,
        input  busy, done, ovf, bcd
    );

    modport slave (
        input  start, num,
        output busy, done, ovf, bcd
    );

endinterface

// File: rtl/bcd_digit_adjust.sv
// One double-dabble correction stage for a single BCD digit.
// Digits of 5 or more get 3 added so the next shift carries correctly.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] adjusted
);

    // add-3 when the digit would become >= 10 after doubling
    always_comb begin
        adjusted = digit;
        if (digit >= 4'd5) begin
            adjusted = digit + 4'd3;
        end
    end

endmodule

// File: rtl/bcd_seq_converter.sv
// Iterative double-dabble converter, one input bit per clock.
// Result digits are registered and only change when a conversion ends.
module bcd_seq_converter
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 13,
    parameter int DIGITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    bcd_seq_converter_if.slave bus
);

    localparam int BCD_W = DIGITS * BCD_DIGIT_W;
    localparam int CNT_W = cnt_width(WIDTH);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   bin_scr;
    logic [BCD_W-1:0]   bcd_scr;
    logic [BCD_W-1:0]   adj;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic [BCD_W-1:0]   bcd_q;
    logic               ovf_q;
    logic               done_q;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit    (bcd_scr[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .adjusted (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state decode; start only matters in IDLE
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.start) state_next = CONVERT;
            CONVERT: if (cnt == CNT_W'(1)) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // scratch shifting during CONVERT, result publish in FINISH
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_scr <= '0;
            bcd_scr <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        bin_scr <= bus.num;
                        bcd_scr <= '0;
                        carry   <= 1'b0;
                        cnt     <= CNT_W'(WIDTH);
                    end
                end
                CONVERT: begin
                    carry   <= carry | adj[BCD_W-1];
                    bcd_scr <= {adj[BCD_W-2:0], bin_scr[WIDTH-1]};
                    bin_scr <= bin_scr << 1;
                    cnt     <= cnt - CNT_W'(1);
                end
                FINISH: begin
                    bcd_q  <= bcd_scr;
                    ovf_q  <= carry;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.ovf  = ovf_q;
    assign bus.bcd  = bcd_q;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Self-checking bench for bcd_seq_converter.
// Default 13-bit instance plus a 14-bit instance that can overflow.
module tb_bcd_seq_converter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    bcd_seq_converter_if #(.WIDTH(13), .DIGITS(4)) bus ();
    bcd_seq_converter_if #(.WIDTH(14), .DIGITS(4)) bus_o ();

    bcd_seq_converter #(.WIDTH(13), .DIGITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    bcd_seq_converter #(.WIDTH(14), .DIGITS(4)) dut_o (
        .clk (clk),
        .rst (rst),
        .bus (bus_o)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // decimal digits of v modulo 10^4, from plain arithmetic
    function automatic logic [15:0] ref_bcd(input int v);
        int r;
        logic [15:0] o;
        r = v % 10000;
        o = '0;
        for (int i = 0; i < 4; i++) begin
            o[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return o;
    endfunction

    // one start pulse; returns digits/ovf at done and edges from accept
    task automatic run_conv(input bit wide, input int v,
                            output logic [15:0] got, output logic gov,
                            output int lat);
        if (wide) begin
            bus_o.num   = 14'(v);
            bus_o.start = 1'b1;
        end else begin
            bus.num   = 13'(v);
            bus.start = 1'b1;
        end
        tick;
        bus.start   = 1'b0;
        bus_o.start = 1'b0;
        lat = -1;
        got = '0;
        gov = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            tick;
            if (wide ? bus_o.done : bus.done) begin
                lat = n;
                got = wide ? bus_o.bcd : bus.bcd;
                gov = wide ? bus_o.ovf : bus.ovf;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick;
        checks++;
        if (bus.bcd !== 16'h0000) begin
            failures++;
            $display("FAIL reset_bcd got=%h exp=0000", bus.bcd);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b exp=0", bus.busy);
        end
        checks++;
        if (bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_done got=%b exp=0", bus.done);
        end
        checks++;
        if (bus.ovf !== 1'b0 || bus_o.ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_ovf got=%b/%b exp=0", bus.ovf, bus_o.ovf);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick;
            checks++;
            if ({bus.busy, bus.done, bus.ovf, bus.bcd} !== 19'h0) begin
                failures++;
                $display("FAIL idle_hold cyc=%0d got=%b%b%b_%h exp=000_0000",
                         i, bus.busy, bus.done, bus.ovf, bus.bcd);
            end
        end
    endtask

    task automatic test_basic;
        bus.num = 13'd1234;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        bus.num = 13'd999;
        for (int k = 1; k <= 13; k++) begin
            checks++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.bcd !== 16'h0000) begin
                failures++;
                $display("FAIL basic_running k=%0d busy=%b done=%b bcd=%h exp=1/0/0000",
                         k, bus.busy, bus.done, bus.bcd);
            end
            tick;
        end
        tick;
        checks++;
        if (bus.done !== 1'b1 || bus.bcd !== 16'h1234 || bus.ovf !== 1'b0) begin
            failures++;
            $display("FAIL basic_result done=%b bcd=%h ovf=%b exp=1/1234/0",
                     bus.done, bus.bcd, bus.ovf);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy_after got=%b exp=0", bus.busy);
        end
        tick;
        checks++;
        if (bus.done !== 1'b0 || bus.bcd !== 16'h1234) begin
            failures++;
            $display("FAIL basic_hold done=%b bcd=%h exp=0/1234", bus.done, bus.bcd);
        end
    endtask

    task automatic test_boundaries;
        int          vals[5] = '{0, 9, 10, 999, 8191};
        logic [15:0] exps[5] = '{16'h0000, 16'h0009, 16'h0010, 16'h0999, 16'h8191};
        logic [15:0] got;
        logic        gov;
        int          lat;
        for (int i = 0; i < 5; i++) begin
            run_conv(1'b0, vals[i], got, gov, lat);
            checks++;
            if (got !== exps[i] || gov !== 1'b0 || lat != 14) begin
                failures++;
                $display("FAIL boundary num=%0d bcd=%h ovf=%b lat=%0d exp=%h/0/14",
                         vals[i], got, gov, lat, exps[i]);
            end
            tick;
        end
    endtask

    task automatic test_busy_lockout;
        int first_lat;
        logic [15:0] got;
        logic gov;
        int lat;
        bus.num = 13'd4321;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        repeat (4) tick;
        bus.num = 13'd7777;
        bus.start = 1'b1;
        first_lat = -1;
        for (int n = 5; n <= 40; n++) begin
            tick;
            if (bus.done) begin
                first_lat = n;
                break;
            end
        end
        checks++;
        if (first_lat != 14 || bus.bcd !== 16'h4321) begin
            failures++;
            $display("FAIL lockout_first lat=%0d bcd=%h exp=14/4321", first_lat, bus.bcd);
        end
        tick;
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL lockout_restart busy=%b exp=1", bus.busy);
        end
        lat = -1;
        got = '0;
        gov = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            tick;
            if (bus.done) begin
                lat = n;
                got = bus.bcd;
                gov = bus.ovf;
                break;
            end
        end
        checks++;
        if (lat != 14 || got !== 16'h7777 || gov !== 1'b0) begin
            failures++;
            $display("FAIL lockout_second lat=%0d bcd=%h ovf=%b exp=14/7777/0", lat, got, gov);
        end
        tick;
    endtask

    task automatic test_mid_reset;
        logic [15:0] got;
        logic gov;
        int lat;
        int seen;
        bus.num = 13'd5678;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        repeat (5) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++;
        if (bus.bcd !== 16'h0000 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL midrst_state bcd=%h busy=%b done=%b exp=0000/0/0",
                     bus.bcd, bus.busy, bus.done);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) seen++;
            tick;
        end
        checks++;
        if (seen != 0 || bus.bcd !== 16'h0000) begin
            failures++;
            $display("FAIL midrst_nodone pulses=%0d bcd=%h exp=0/0000", seen, bus.bcd);
        end
        run_conv(1'b0, 42, got, gov, lat);
        checks++;
        if (got !== 16'h0042 || lat != 14) begin
            failures++;
            $display("FAIL midrst_after bcd=%h lat=%0d exp=0042/14", got, lat);
        end
        tick;
    endtask

    task automatic test_overflow;
        int          vals[4] = '{12345, 9999, 10000, 16383};
        logic [15:0] exps[4] = '{16'h2345, 16'h9999, 16'h0000, 16'h6383};
        logic        eovf[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [15:0] got;
        logic        gov;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            run_conv(1'b1, vals[i], got, gov, lat);
            checks++;
            if (got !== exps[i] || gov !== eovf[i] || lat != 15) begin
                failures++;
                $display("FAIL overflow num=%0d bcd=%h ovf=%b lat=%0d exp=%h/%b/15",
                         vals[i], got, gov, lat, exps[i], eovf[i]);
            end
            tick;
        end
    endtask

    task automatic test_random_sweep;
        logic [15:0] got;
        logic        gov;
        int          lat;
        int          v;
        for (int i = 0; i < 1000; i++) begin
            v = int'($urandom_range(0, 16383));
            run_conv(1'b1, v, got, gov, lat);
            checks++;
            if (got !== ref_bcd(v) || gov !== (v > 9999) || lat != 15) begin
                failures++;
                $display("FAIL sweep14 num=%0d bcd=%h ovf=%b lat=%0d exp=%h/%b/15",
                         v, got, gov, lat, ref_bcd(v), (v > 9999));
            end
            tick;
        end
        for (int i = 0; i < 200; i++) begin
            v = int'($urandom_range(0, 8191));
            run_conv(1'b0, v, got, gov, lat);
            checks++;
            if (got !== ref_bcd(v) || gov !== 1'b0 || lat != 14) begin
                failures++;
                $display("FAIL sweep13 num=%0d bcd=%h ovf=%b lat=%0d exp=%h/0/14",
                         v, got, gov, lat, ref_bcd(v));
            end
            tick;
        end
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.num     = '0;
        bus_o.start = 1'b0;
        bus_o.num   = '0;
        test_reset();
        test_basic();
        test_boundaries();
        test_busy_lockout();
        test_mid_reset();
        test_overflow();
        test_random_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
